pkt_rx_checker: RTL and testbench

//  Receive-side end of the per-port packet interface: consumes one output port's rd_sop/rd_eop/rd_vld/rd_data from top_nxn.

---
 rtl/pkt_rx_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_pkt_rx_checker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_checker.sv
// Receive-side packet checker: parses the header beat, checks payload sequence and length, and reports per-packet results and counters.
// Optional build macro RX_BACKPRESSURE_EN adds LFSR-driven ready throttling with a protocol check.
module pkt_rx_checker #(
  parameter int unsigned RX_PORT         = 0,
  parameter int unsigned PORT_NUB_TOTAL  = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PRIORITY        = 8,
  parameter int unsigned DATA_LENGTH_MAX = 128,
  localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
  localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY),
  localparam int unsigned WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_sop,
  input  logic                      rd_eop,
  input  logic                      rd_vld,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      ready,
  output logic                      pkt_done,
  output logic [WIDTH_SEL-1:0]      pkt_src,
  output logic [WIDTH_PRIORITY-1:0] pkt_pri,
  output logic [WIDTH_LENGTH-1:0]   pkt_len,
  output logic [3:0]                pkt_err,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               err_cnt
);

  localparam int unsigned PRI_LSB = WIDTH_SEL;
  localparam int unsigned LEN_LSB = WIDTH_SEL + WIDTH_PRIORITY;
  localparam int unsigned SRC_LSB = DATA_WIDTH - WIDTH_SEL;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_t;

  state_t                    state, state_n;
  logic [WIDTH_SEL-1:0]      src_q, src_n;
  logic [WIDTH_PRIORITY-1:0] pri_q, pri_n;
  logic [WIDTH_LENGTH-1:0]   hlen_q, hlen_n;
  logic [WIDTH_LENGTH-1:0]   beat_q, beat_n;
  logic                      dest_err_q, dest_err_n;
  logic                      len_err_q, len_err_n;
  logic                      data_err_q, data_err_n;
  logic                      proto_q, proto_n;
  logic                      done_n;
  logic [WIDTH_SEL-1:0]      res_src_n;
  logic [WIDTH_PRIORITY-1:0] res_pri_n;
  logic [WIDTH_LENGTH-1:0]   res_len_n;
  logic [3:0]                res_err_n;
  logic                      load_hdr_c;
  logic                      data_bad_c;
  logic                      len_bad_c;
  logic [WIDTH_LENGTH-1:0]   len_rx_c;
  logic                      bp_viol_c;
  logic                      unused_bits;

  // Only the header/payload fields are inspected; the remaining data bits are don't-care.
  assign unused_bits = ^rd_data;

`ifdef RX_BACKPRESSURE_EN
  logic [7:0] lfsr;

  // Free-running LFSR throttles ready; beats offered while throttled are protocol errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= 8'hA5;
      ready <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      ready <= (lfsr[1:0] != 2'b00);
    end
  end

  assign bp_viol_c = ~ready;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready <= 1'b0;
    else     ready <= 1'b1;
  end

  assign bp_viol_c = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    src_n      = src_q;
    pri_n      = pri_q;
    hlen_n     = hlen_q;
    beat_n     = beat_q;
    dest_err_n = dest_err_q;
    len_err_n  = len_err_q;
    data_err_n = data_err_q;
    proto_n    = proto_q;
    done_n     = 1'b0;
    res_src_n  = pkt_src;
    res_pri_n  = pkt_pri;
    res_len_n  = pkt_len;
    res_err_n  = pkt_err;
    load_hdr_c = 1'b0;
    data_bad_c = (rd_data[15:0] != 16'(beat_q)) || (rd_data[SRC_LSB +: WIDTH_SEL] != src_q);
    len_rx_c   = beat_q + WIDTH_LENGTH'(1);
    len_bad_c  = (len_rx_c != hlen_q);

    case (state)
      S_IDLE: begin
        if (rd_vld) begin
          if (rd_sop) begin
            load_hdr_c = 1'b1;
          end else begin
            // Stray beat with no header: report it as a bare protocol error.
            src_n      = '0;
            pri_n      = '0;
            hlen_n     = '0;
            beat_n     = '0;
            dest_err_n = 1'b0;
            len_err_n  = 1'b0;
            data_err_n = 1'b0;
            proto_n    = 1'b1;
            if (rd_eop) begin
              done_n    = 1'b1;
              res_src_n = '0;
              res_pri_n = '0;
              res_len_n = '0;
              res_err_n = 4'b1000;
            end else begin
              state_n = S_DRAIN;
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (rd_vld) begin
          if (rd_sop) begin
            done_n     = 1'b1;
            res_src_n  = src_q;
            res_pri_n  = pri_q;
            res_len_n  = beat_q;
            res_err_n  = {1'b1, data_err_q, len_err_q, dest_err_q};
            load_hdr_c = 1'b1;
          end else begin
            data_err_n = data_err_q | data_bad_c;
            proto_n    = proto_q | bp_viol_c;
            if (rd_eop) begin
              done_n    = 1'b1;
              res_src_n = src_q;
              res_pri_n = pri_q;
              res_len_n = len_rx_c;
              res_err_n = {proto_n, data_err_n, len_bad_c, dest_err_q};
              state_n   = S_IDLE;
            end else if (beat_q == WIDTH_LENGTH'(DATA_LENGTH_MAX - 1)) begin
              len_err_n = 1'b1;
              proto_n   = 1'b1;
              state_n   = S_DRAIN;
            end else begin
              beat_n = len_rx_c;
            end
          end
        end
      end

      S_DRAIN: begin
        if (rd_vld) begin
          proto_n = proto_q | bp_viol_c;
          if (rd_eop) begin
            done_n    = 1'b1;
            res_src_n = src_q;
            res_pri_n = pri_q;
            res_len_n = beat_q;
            res_err_n = {proto_n, data_err_q, len_err_q, dest_err_q};
            state_n   = S_IDLE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Header beat opens a new packet, including back-to-back after an aborted one.
    if (load_hdr_c) begin
      dest_err_n = (rd_data[WIDTH_SEL-1:0] != WIDTH_SEL'(RX_PORT));
      pri_n      = rd_data[PRI_LSB +: WIDTH_PRIORITY];
      hlen_n     = rd_data[LEN_LSB +: WIDTH_LENGTH];
      src_n      = rd_data[SRC_LSB +: WIDTH_SEL];
      beat_n     = '0;
      len_err_n  = 1'b0;
      data_err_n = 1'b0;
      proto_n    = bp_viol_c;
      state_n    = S_PAYLOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      src_q      <= '0;
      pri_q      <= '0;
      hlen_q     <= '0;
      beat_q     <= '0;
      dest_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      data_err_q <= 1'b0;
      proto_q    <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_src    <= '0;
      pkt_pri    <= '0;
      pkt_len    <= '0;
      pkt_err    <= '0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      src_q      <= src_n;
      pri_q      <= pri_n;
      hlen_q     <= hlen_n;
      beat_q     <= beat_n;
      dest_err_q <= dest_err_n;
      len_err_q  <= len_err_n;
      data_err_q <= data_err_n;
      proto_q    <= proto_n;
      pkt_done   <= done_n;
      pkt_src    <= res_src_n;
      pkt_pri    <= res_pri_n;
      pkt_len    <= res_len_n;
      pkt_err    <= res_err_n;
      if (done_n) begin
        pkt_cnt <= pkt_cnt + 16'd1;
        if (res_err_n != 4'b0000) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Scoreboard bench for pkt_rx_checker (RX_PORT=3): directed packets push expected results; a monitor pops on pkt_done.
module tb_pkt_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_sop, rd_eop, rd_vld;
  logic [31:0] rd_data;
  logic        ready, pkt_done;
  logic [3:0]  pkt_src;
  logic [2:0]  pkt_pri;
  logic [6:0]  pkt_len;
  logic [3:0]  pkt_err;
  logic [15:0] pkt_cnt, err_cnt;

  typedef struct packed {
    logic [3:0]  src;
    logic [2:0]  pri;
    logic [6:0]  len;
    logic [3:0]  err;
    logic [15:0] pcnt;
    logic [15:0] ecnt;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] m_pcnt = 16'd0;
  logic [15:0] m_ecnt = 16'd0;

  pkt_rx_checker #(.RX_PORT(3)) dut (
    .clk(clk), .rst(rst), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld),
    .rd_data(rd_data), .ready(ready), .pkt_done(pkt_done), .pkt_src(pkt_src),
    .pkt_pri(pkt_pri), .pkt_len(pkt_len), .pkt_err(pkt_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input logic [3:0] src, input logic [2:0] pri,
                              input logic [6:0] len, input logic [3:0] err);
    exp_t e;
    m_pcnt = m_pcnt + 16'd1;
    if (err != 4'd0) m_ecnt = m_ecnt + 16'd1;
    e.src = src; e.pri = pri; e.len = len; e.err = err;
    e.pcnt = m_pcnt; e.ecnt = m_ecnt; e.cyc = 32'd0;
    return e;
  endfunction

  // Drive one beat for a cycle; optionally queue an expected result due one cycle after capture.
  task automatic beat(input logic sop, input logic eop, input logic [31:0] data,
                      input logic push, input exp_t e);
    exp_t x;
    @(posedge clk); #1;
    rd_vld = 1'b1; rd_sop = sop; rd_eop = eop; rd_data = data;
    if (push) begin
      x = e;
      x.cyc = 32'(cyc + 1);
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = 32'h0;
    end
  endtask

  // Header then nbeats payload beats; stop_at < nbeats truncates without eop. prev is queued on the header beat.
  task automatic send_pkt(input logic [3:0] dest, input logic [2:0] pri, input logic [6:0] hlen,
                          input logic [3:0] src, input int nbeats, input int stop_at,
                          input int bad_idx, input logic [15:0] bad_val,
                          input logic push_prev, input exp_t prev, input exp_t e);
    logic [15:0] k16;
    beat(1'b1, 1'b0, {src, 14'h0, hlen, pri, dest}, push_prev, prev);
    for (int k = 0; k < nbeats && k < stop_at; k++) begin
      k16 = (k == bad_idx) ? bad_val : 16'(k);
      beat(1'b0, (k == nbeats - 1), {src, 12'h0, k16}, (k == nbeats - 1), e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pkt_done) begin
      if (q.size() == 0) begin
        chk("unexpected_pkt_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 32'(cyc), e.cyc);
        chk("pkt_src", 32'(pkt_src), 32'(e.src));
        chk("pkt_pri", 32'(pkt_pri), 32'(e.pri));
        chk("pkt_len", 32'(pkt_len), 32'(e.len));
        chk("pkt_err", 32'(pkt_err), 32'(e.err));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(e.pcnt));
        chk("err_cnt", 32'(err_cnt), 32'(e.ecnt));
      end
    end
  end

  task automatic reset_and_check(input string tag);
    @(posedge clk); #1;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = 32'h0;
    rst = 1'b1;
    m_pcnt = 16'd0; m_ecnt = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst_ready"}, 32'(ready), 32'd0);
    chk({tag, "_rst_done"}, 32'(pkt_done), 32'd0);
    chk({tag, "_rst_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    chk({tag, "_rst_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_rst_err"}, 32'(pkt_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_after_rst"}, 32'(ready), 32'd1);
  endtask

  initial begin
    exp_t none, a, b;
    none = '0;
    rst = 1'b1; rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = 32'h0;
    reset_and_check("init");

    // Clean packet, then header immediately after eop (wrong dest)
    send_pkt(4'd3, 3'd1, 7'd16, 4'd5, 16, 99, -1, 16'h0, 1'b0, none, mk(4'd5, 3'd1, 7'd16, 4'b0000));
    send_pkt(4'd7, 3'd2, 7'd20, 4'd6, 20, 99, -1, 16'h0, 1'b0, none, mk(4'd6, 3'd2, 7'd20, 4'b0001));
    idle(2);
    // Short packet: header says 20, eop on beat 17
    send_pkt(4'd3, 3'd0, 7'd20, 4'd2, 18, 99, -1, 16'h0, 1'b0, none, mk(4'd2, 3'd0, 7'd18, 4'b0010));
    idle(1);
    // Bad sequence number on payload beat 5
    send_pkt(4'd3, 3'd3, 7'd16, 4'd1, 16, 99, 5, 16'd9, 1'b0, none, mk(4'd1, 3'd3, 7'd16, 4'b0100));
    idle(1);
    // New header at payload beat 10 aborts the first packet
    send_pkt(4'd3, 3'd4, 7'd30, 4'd7, 30, 10, -1, 16'h0, 1'b0, none, none);
    a = mk(4'd7, 3'd4, 7'd10, 4'b1000);
    b = mk(4'd4, 3'd5, 7'd16, 4'b0000);
    send_pkt(4'd3, 3'd5, 7'd16, 4'd4, 16, 99, -1, 16'h0, 1'b1, a, b);
    idle(2);
    // Stray eop beat with no header
    beat(1'b0, 1'b1, 32'h0000_0000, 1'b1, mk(4'd0, 3'd0, 7'd0, 4'b1000));
    idle(3);
    // Reset mid-payload, then a clean packet
    send_pkt(4'd3, 3'd1, 7'd16, 4'd5, 16, 8, -1, 16'h0, 1'b0, none, none);
    reset_and_check("mid");
    send_pkt(4'd3, 3'd6, 7'd16, 4'd9, 16, 99, -1, 16'h0, 1'b0, none, mk(4'd9, 3'd6, 7'd16, 4'b0000));
    idle(1);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    chk("final_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("final_err_cnt", 32'(err_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
